// File: rtl/fetch_if.sv
// Fetch-stage port bundle: hazard/execute controls, instruction-memory port, IF/ID outputs.
// FETCH_PERF_CNT_EN adds the fetch/stall/flush counter outputs.
interface fetch_if #(
    parameter int WIDTH = 32
);
    logic             stall_f;
    logic             flush_d;
    logic             pcsrc_e;
    logic [WIDTH-1:0] pc_target_e;
    logic [WIDTH-1:0] imem_addr;
    logic [WIDTH-1:0] imem_rdata;
    logic [WIDTH-1:0] instr_d;
    logic [WIDTH-1:0] pc_d;
    logic [WIDTH-1:0] pcplus4_d;
    logic             valid_d;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0]      fetch_cnt;
    logic [31:0]      stall_cnt;
    logic [31:0]      flush_cnt;

    modport master (
        output stall_f, flush_d, pcsrc_e, pc_target_e, imem_rdata,
        input  imem_addr, instr_d, pc_d, pcplus4_d, valid_d,
        input  fetch_cnt, stall_cnt, flush_cnt
    );
    modport slave (
        input  stall_f, flush_d, pcsrc_e, pc_target_e, imem_rdata,
        output imem_addr, instr_d, pc_d, pcplus4_d, valid_d,
        output fetch_cnt, stall_cnt, flush_cnt
    );
`else
    modport master (
        output stall_f, flush_d, pcsrc_e, pc_target_e, imem_rdata,
        input  imem_addr, instr_d, pc_d, pcplus4_d, valid_d
    );
    modport slave (
        input  stall_f, flush_d, pcsrc_e, pc_target_e, imem_rdata,
        output imem_addr, instr_d, pc_d, pcplus4_d, valid_d
    );
`endif
endinterface

// File: rtl/fetch_stage.sv
// RV32I instruction fetch: PC register plus IF/ID pipeline register.
// Optional FETCH_PERF_CNT_EN adds fetch/stall/flush event counters.
module fetch_stage #(
    parameter int               WIDTH     = 32,
    parameter logic [WIDTH-1:0] RESET_PC  = '0,
    parameter logic [WIDTH-1:0] NOP_INSTR = WIDTH'(32'h0000_0013)
) (
    input  logic  clk,
    input  logic  rst,
    fetch_if.slave fif
);
    typedef struct packed {
        logic [WIDTH-1:0] instr;
        logic [WIDTH-1:0] pc;
        logic [WIDTH-1:0] pcplus4;
        logic             valid;
    } ifid_t;

    localparam ifid_t BUBBLE = '{instr: NOP_INSTR, pc: '0, pcplus4: '0, valid: 1'b0};

    logic [WIDTH-1:0] pc_q, pc_next, pc_plus4, target;
    ifid_t            ifid_q, ifid_next;

    assign pc_plus4 = pc_q + WIDTH'(4);
    // No compressed ISA: low target bits are dropped, not trapped.
    assign target   = fif.pc_target_e & ~WIDTH'(3);

    always_comb begin
        pc_next = pc_plus4;
        if (rst)              pc_next = RESET_PC;
        else if (fif.pcsrc_e) pc_next = target;
        else if (fif.stall_f) pc_next = pc_q;
    end

    always_comb begin
        ifid_next = '{instr: fif.imem_rdata, pc: pc_q, pcplus4: pc_plus4, valid: 1'b1};
        if (rst || fif.flush_d) ifid_next = BUBBLE;
        else if (fif.stall_f)   ifid_next = ifid_q;
    end

    always_ff @(posedge clk) begin
        pc_q   <= pc_next;
        ifid_q <= ifid_next;
    end

    assign fif.imem_addr = pc_q;
    assign fif.instr_d   = ifid_q.instr;
    assign fif.pc_d      = ifid_q.pc;
    assign fif.pcplus4_d = ifid_q.pcplus4;
    assign fif.valid_d   = ifid_q.valid;

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] fetch_cnt_q, stall_cnt_q, flush_cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_cnt_q <= '0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (fif.flush_d)      flush_cnt_q <= flush_cnt_q + 32'd1;
            else if (fif.stall_f) stall_cnt_q <= stall_cnt_q + 32'd1;
            else                  fetch_cnt_q <= fetch_cnt_q + 32'd1;
        end
    end

    assign fif.fetch_cnt = fetch_cnt_q;
    assign fif.stall_cnt = stall_cnt_q;
    assign fif.flush_cnt = flush_cnt_q;
`endif
endmodule
